// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler that shares one iterative radix-2 Booth multiplier among NREQ requesters.
// Results return as the signed 2W-bit product, tagged with the index of the winning requester.
module booth_mult_scheduler #(
  parameter int unsigned W    = 4,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*W-1:0]      rsp_prod,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0]  LastCnt = CW'(W - 1);
  localparam logic [IDW-1:0] LastId  = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NreqExt = NREQ[IDW:0];

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StResp
  } state_e;

  state_e          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [IDW-1:0]  id_q;
  logic [W:0]      m_q;
  logic [W:0]      acc_q;
  logic [W-1:0]    q_q;
  logic            q1_q;

  // Arbitration
  logic            any_valid;
  logic [NREQ-1:0] valid_rot;
  logic [IDW-1:0]  offset;
  logic [IDW:0]    grant_sum;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  rr_ptr_nxt;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;

  // Booth datapath
  logic [W:0]      acc_sum;
  logic [W:0]      acc_shift;
  logic [W-1:0]    q_shift;

  assign any_valid = |req_valid;

  // Rotate so bit 0 is the lane at rr_ptr; the lowest set bit is then the round-robin winner.
  assign valid_rot = NREQ'({req_valid, req_valid} >> rr_ptr_q);

  always_comb begin
    offset = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        offset = IDW'(k);
      end
    end
  end

  assign grant_sum = {1'b0, rr_ptr_q} + {1'b0, offset};

  always_comb begin
    if (grant_sum >= NreqExt) begin
      grant = IDW'(grant_sum - NreqExt);
    end else begin
      grant = IDW'(grant_sum);
    end
  end

  assign rr_ptr_nxt = (grant == LastId) ? '0 : grant + 1'b1;

  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == StIdle) && any_valid) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (grant == IDW'(k)) begin
        a_sel = req_a[k*W +: W];
        b_sel = req_b[k*W +: W];
      end
    end
  end

  // One Booth step: add/subtract M by the {Q0, Q-1} pair, then arithmetic shift of {ACC, Q, Q-1}.
  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   acc_sum = acc_q + m_q;
      2'b10:   acc_sum = acc_q - m_q;
      default: acc_sum = acc_q;
    endcase
  end

  assign acc_shift = {acc_sum[W], acc_sum[W:1]};
  assign q_shift   = {acc_sum[0], q_q[W-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            m_q      <= {a_sel[W-1], a_sel};
            acc_q    <= '0;
            q_q      <= b_sel;
            q1_q     <= 1'b0;
            id_q     <= grant;
            rr_ptr_q <= rr_ptr_nxt;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_shift;
          q_q   <= q_shift;
          q1_q  <= q_q[0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            rsp_valid <= 1'b1;
            rsp_prod  <= {acc_shift[W-1:0], q_shift};
            rsp_id    <= id_q;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_prod) && $stable(rsp_id)));

endmodule
